// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared widths and FSM state encoding for the RAM bus master
package mem_bus_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W_DEF = 9;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD_ISSUE = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_RD_CAPT = 3'd3;
  localparam logic [2:0] ST_WR_ISSUE = 3'd4;
  localparam logic [2:0] ST_ERR = 3'd5;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    RD_ISSUE = ST_RD_ISSUE,
    RD_WAIT = ST_RD_WAIT,
    RD_CAPT = ST_RD_CAPT,
    WR_ISSUE = ST_WR_ISSUE,
    ERR = ST_ERR
  } state_t;
endpackage

// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if: control-unit request/response handshake plus the RAM port
interface mem_bus_master_if import mem_bus_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic rsp_valid;
  logic rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic mem_enableWrite;
  logic mem_enableRead;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    input req_valid, req_write, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_address, mem_wdata, mem_enableWrite, mem_enableRead
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata,
    input req_ready, rsp_valid, rsp_err, rsp_rdata, mem_address, mem_wdata, mem_enableWrite, mem_enableRead
  );
endinterface

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: 4-bit read wait-state counter with load, decrement and zero flag
module mem_wait_counter (
  input logic clock,
  input logic clear,
  input logic load,
  input logic dec,
  input logic [3:0] init,
  output logic zero
);
  logic [3:0] cnt;
  // load wins over decrement; decrement holds at zero so the count never wraps
  always_ff @(posedge clock)
    cnt <= clear ? 4'd0 : load ? init : (dec && !zero) ? cnt - 4'd1 : cnt;
  assign zero = cnt == 4'd0;
endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: sequences single load/store transfers from the control unit into the synchronous RAM
module mem_bus_master import mem_bus_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WAIT_STATES = 0
) (
  input logic clock,
  input logic clear,
  mem_bus_master_if.master bus
);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  state_t state;
  logic wait_zero;
  mem_wait_counter u_wait (
    .clock(clock),
    .clear(clear),
    .load(state == RD_ISSUE),
    .dec(state == RD_WAIT),
    .init(WAIT_INIT),
    .zero(wait_zero)
  );
  // request latch, FSM and registered response; upper address bits only feed the range check
  always_ff @(posedge clock)
    if (clear) begin
      state <= IDLE;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.mem_address <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.rsp_valid <= state inside {WR_ISSUE, RD_CAPT, ERR};
      bus.rsp_err <= state == ERR;
      case (state)
        IDLE: if (bus.req_valid) begin
          bus.mem_address <= bus.req_addr[ADDR_W-1:0];
          bus.mem_wdata <= bus.req_wdata;
          state <= |bus.req_addr[DATA_W-1:ADDR_W] ? ERR : bus.req_write ? WR_ISSUE : RD_ISSUE;
        end
        RD_ISSUE: state <= WAIT_STATES == 0 ? RD_CAPT : RD_WAIT;
        RD_WAIT: if (wait_zero) state <= RD_CAPT;
        RD_CAPT: begin
          bus.rsp_rdata <= bus.mem_rdata;
          state <= IDLE;
        end
        ERR: begin
          bus.rsp_rdata <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.req_ready = state == IDLE;
  assign bus.mem_enableRead = state == RD_ISSUE;
  assign bus.mem_enableWrite = state == WR_ISSUE;
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed tests of mem_bus_master against a transaction-level model
module tb_mem_bus_master;
  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  int sel = 0;
  logic pl_en = 1'b0;
  logic [8:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  int checks = 0;
  int errors = 0;
  int we_tot = 0;
  int re_tot = 0;
  logic [8:0] we_addr = '0;
  logic [31:0] ram [512];
  logic [31:0] ram_q;
  logic ready_x, valid_x, err_x, we_x, re_x;
  logic [31:0] rdata_x, wdata_x;
  logic [8:0] addr_x;

  mem_bus_master_if #(.ADDR_W(9)) b0 ();
  mem_bus_master_if #(.ADDR_W(9)) b1 ();
  mem_bus_master_if #(.ADDR_W(9)) b2 ();
  mem_bus_master #(.ADDR_W(9), .WAIT_STATES(0)) u0 (.clock(clock), .clear(clear), .bus(b0.master));
  mem_bus_master #(.ADDR_W(9), .WAIT_STATES(2)) u1 (.clock(clock), .clear(clear), .bus(b1.master));
  mem_bus_master #(.ADDR_W(9), .WAIT_STATES(3)) u2 (.clock(clock), .clear(clear), .bus(b2.master));

  assign b0.req_valid = req_valid && sel == 0;
  assign b1.req_valid = req_valid && sel == 1;
  assign b2.req_valid = req_valid && sel == 2;
  assign b0.req_write = req_write;
  assign b1.req_write = req_write;
  assign b2.req_write = req_write;
  assign b0.req_addr = req_addr;
  assign b1.req_addr = req_addr;
  assign b2.req_addr = req_addr;
  assign b0.req_wdata = req_wdata;
  assign b1.req_wdata = req_wdata;
  assign b2.req_wdata = req_wdata;
  assign b0.mem_rdata = ram_q;
  assign b1.mem_rdata = ram_q;
  assign b2.mem_rdata = ram_q;

  assign ready_x = sel == 0 ? b0.req_ready : sel == 1 ? b1.req_ready : b2.req_ready;
  assign valid_x = sel == 0 ? b0.rsp_valid : sel == 1 ? b1.rsp_valid : b2.rsp_valid;
  assign err_x = sel == 0 ? b0.rsp_err : sel == 1 ? b1.rsp_err : b2.rsp_err;
  assign rdata_x = sel == 0 ? b0.rsp_rdata : sel == 1 ? b1.rsp_rdata : b2.rsp_rdata;
  assign addr_x = sel == 0 ? b0.mem_address : sel == 1 ? b1.mem_address : b2.mem_address;
  assign wdata_x = sel == 0 ? b0.mem_wdata : sel == 1 ? b1.mem_wdata : b2.mem_wdata;
  assign we_x = sel == 0 ? b0.mem_enableWrite : sel == 1 ? b1.mem_enableWrite : b2.mem_enableWrite;
  assign re_x = sel == 0 ? b0.mem_enableRead : sel == 1 ? b1.mem_enableRead : b2.mem_enableRead;

  // synchronous RAM with registered output, plus a bench-side preload port
  always @(posedge clock) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    if (we_x) ram[addr_x] <= wdata_x;
    if (re_x) ram_q <= ram[addr_x];
  end

  // enable activity monitor
  always @(negedge clock) begin
    we_tot <= we_tot + int'(we_x);
    re_tot <= re_tot + int'(re_x);
    if (we_x) we_addr <= addr_x;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // transaction model: one access at a time, response latency 2 (store/error) or 3+W (load)
  initial begin
    int t, lat, w;
    bit busy, m_wr, m_err;
    logic [8:0] m_addr;
    logic [31:0] m_wdata, e_rdata;
    logic e_valid, e_err;
    logic [31:0] mm [512];
    t = 0; lat = 0; busy = 0; m_wr = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; e_rdata = '0; e_valid = 0; e_err = 0;
    forever begin
      @(posedge clock);
      w = sel == 0 ? 0 : sel == 1 ? 2 : 3;
      if (pl_en) mm[pl_addr] = pl_data;
      if (busy && t == 1 && m_wr && !m_err) mm[m_addr] = m_wdata;
      e_valid = 0;
      e_err = 0;
      if (clear) begin
        busy = 0; e_rdata = '0; m_addr = '0; m_wdata = '0;
      end else if (busy) begin
        t++;
        if (t == lat) begin
          busy = 0; e_valid = 1; e_err = m_err;
          e_rdata = m_err ? 32'h0 : m_wr ? e_rdata : mm[m_addr];
        end
      end else if (req_valid) begin
        busy = 1; t = 1; m_wr = req_write; m_err = req_addr[31:9] != 0;
        m_addr = req_addr[8:0]; m_wdata = req_wdata;
        lat = m_err ? 2 : m_wr ? 2 : 3 + w;
      end
      @(negedge clock);
      chk("req_ready", 32'(ready_x), 32'(!busy));
      chk("rsp_valid", 32'(valid_x), 32'(e_valid));
      if (e_valid) chk("rsp_err", 32'(err_x), 32'(e_err));
      chk("rsp_rdata", rdata_x, e_rdata);
      chk("mem_address", 32'(addr_x), 32'(m_addr));
      chk("mem_wdata", wdata_x, m_wdata);
      chk("mem_enableWrite", 32'(we_x), 32'(busy && t == 1 && m_wr && !m_err));
      chk("mem_enableRead", 32'(re_x), 32'(busy && t == 1 && !m_wr && !m_err));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // holds the request until accepted, scrambles the request fields while busy, returns at the response cycle
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat, output int waits);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    waits = 0;
    while (!ready_x && waits < 50) begin
      tick();
      waits++;
    end
    tick();
    lat = 1;
    while (!valid_x && lat < 40) begin
      req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom);
      tick();
      lat++;
    end
    req_valid = 0;
    rd = rdata_x;
    er = err_x;
  endtask

  task automatic select(input int s);
    clear = 1;
    tick();
    sel = s;
    clear = 0;
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    pl_en = 1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 0;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, waits, w0, r0, nv;
    tick();
    tick();
    chk("reset_ready", 32'(ready_x), 32'd1);
    chk("reset_rdata", rdata_x, 32'h0);
    clear = 0;
    w0 = we_tot; r0 = re_tot;
    xfer(1, 32'h87, 32'h43, rd, er, lat, waits);
    chk("t1_store_lat", lat, 2);
    chk("t1_we_cycles", we_tot - w0, 1);
    chk("t1_we_addr", 32'(we_addr), 32'h087);
    xfer(0, 32'h87, 32'h0, rd, er, lat, waits);
    chk("t1_load_data", rd, 32'h43);
    chk("t1_load_err", 32'(er), 0);
    chk("t1_load_lat", lat, 3);
    w0 = we_tot; r0 = re_tot;
    xfer(0, 32'h200, 32'h0, rd, er, lat, waits);
    chk("t3_err_lat", lat, 2);
    chk("t3_err_flag", 32'(er), 1);
    chk("t3_err_rdata", rd, 32'h0);
    chk("t3_no_enables", (we_tot - w0) + (re_tot - r0), 0);
    xfer(1, 32'h0, 32'h12345678, rd, er, lat, waits);
    chk("t3_next_accept_wait", waits, 0);
    chk("t3_next_lat", lat, 2);
    xfer(1, 32'h10, 32'hA5A5A5A5, rd, er, lat, waits);
    xfer(0, 32'h10, 32'h0, rd, er, lat, waits);
    chk("t4_b2b_wait", waits, 0);
    chk("t4_b2b_data", rd, 32'hA5A5A5A5);
    chk("t4_b2b_lat", lat, 3);
    xfer(1, 32'h1AB, 32'hDEADBEEF, rd, er, lat, waits);
    chk("t6_we_addr", 32'(we_addr), 32'h1AB);
    xfer(0, 32'h1AB, 32'h0, rd, er, lat, waits);
    chk("t6_load_data", rd, 32'hDEADBEEF);
    select(1);
    preload(9'h075, 32'hFFFFFFF0);
    r0 = re_tot;
    xfer(0, 32'h75, 32'h0, rd, er, lat, waits);
    chk("t2_lat", lat, 5);
    chk("t2_data", rd, 32'hFFFFFFF0);
    chk("t2_re_cycles", re_tot - r0, 1);
    select(2);
    xfer(0, 32'h75, 32'h0, rd, er, lat, waits);
    chk("t5_pre_data", rd, 32'hFFFFFFF0);
    chk("t5_pre_lat", lat, 6);
    req_valid = 1; req_write = 0; req_addr = 32'h10;
    tick();
    req_valid = 0;
    tick();
    clear = 1;
    tick();
    clear = 0;
    chk("t5_ready_after_clear", 32'(ready_x), 32'd1);
    chk("t5_enables_after_clear", 32'(we_x | re_x), 32'd0);
    chk("t5_rdata_after_clear", rdata_x, 32'h0);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      nv += int'(valid_x);
      tick();
    end
    chk("t5_no_rsp", nv, 0);
    xfer(0, 32'h75, 32'h0, rd, er, lat, waits);
    chk("t5_post_data", rd, 32'hFFFFFFF0);
    chk("t5_post_lat", lat, 6);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
